// File: rtl/adc_osr_pkg.sv
// rtl/adc_osr_pkg.sv - shared widths, mode clamp and rounding helpers for the OSR unit
package adc_osr_pkg;

  localparam int MAX_MODE_DEF = 4;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int out_w(input int data_w, input int max_mode);
    return data_w + max_mode;
  endfunction

  function automatic int acc_w(input int data_w, input int max_mode);
    return data_w + 2 * max_mode;
  endfunction

  function automatic logic [2:0] clamp_mode(input logic [2:0] mode, input int max_mode);
    return (int'(mode) > max_mode) ? 3'(max_mode) : mode;
  endfunction

  // Half an output LSB, so the right shift rounds to nearest.
  function automatic int round_offset(input logic [2:0] mode);
    return (mode == 3'd0) ? 0 : (1 << (int'(mode) - 1));
  endfunction

endpackage

// File: rtl/adc_osr_ch_acc.sv
// rtl/adc_osr_ch_acc.sv - per-channel accumulator, sample counter, mode latch and rounded result
module adc_osr_ch_acc
  import adc_osr_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int MAX_MODE = MAX_MODE_DEF,
  parameter int ACC_W    = acc_w(DATA_W, MAX_MODE),
  parameter int OUT_W    = out_w(DATA_W, MAX_MODE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [2:0]        mode_in,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  result
);

  localparam int CNT_W = (MAX_MODE > 0) ? 2 * MAX_MODE : 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [2:0]       mode_q;
  logic [2:0]       mode_eff;

  // The first sample of a block uses the live mode; later samples use the latched one.
  always_comb begin
    mode_eff = (cnt == '0) ? mode_in : mode_q;
    last     = CNT_W'((1 << (2 * int'(mode_eff))) - 1);
    sum      = acc + ACC_W'(data);
    done     = sample_valid && (cnt == last);
    result   = OUT_W'((sum + ACC_W'(round_offset(mode_eff))) >> mode_eff);
    busy     = (cnt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      mode_q <= '0;
    end else if (clear) begin
      acc    <= '0;
      cnt    <= '0;
      mode_q <= '0;
    end else if (sample_valid) begin
      if (cnt == '0) mode_q <= mode_in;
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_osr_multich.sv
// rtl/adc_osr_multich.sv - multi-channel oversampling/decimation with valid/ready output register
module adc_osr_multich
  import adc_osr_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int NUM_CH   = 2,
  parameter int MAX_MODE = MAX_MODE_DEF,
  parameter int CH_W     = ch_w(NUM_CH),
  parameter int OUT_W    = out_w(DATA_W, MAX_MODE),
  parameter int ACC_W    = acc_w(DATA_W, MAX_MODE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_in,
  input  logic [2:0]        osr_mode_in,
  input  logic              data_valid_in,
  input  logic [CH_W-1:0]   data_ch_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [OUT_W-1:0]  result_out,
  output logic [CH_W-1:0]   result_ch_out,
  output logic              result_valid_out,
  input  logic              result_ready_in,
  output logic              overrun_out,
  output logic [NUM_CH-1:0] busy_out
);

  logic [2:0]        mode_c;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] done;
  logic [OUT_W-1:0]  ch_res [NUM_CH];
  logic              any_done;
  logic [OUT_W-1:0]  new_res;
  logic [CH_W-1:0]   new_ch;
  logic              transfer;

  assign mode_c = clamp_mode(osr_mode_in, MAX_MODE);

  // Tags >= NUM_CH match no channel and are dropped here.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel[i] = data_valid_in && !clear_in && (data_ch_in == CH_W'(i));

    adc_osr_ch_acc #(
      .DATA_W  (DATA_W),
      .MAX_MODE(MAX_MODE),
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W)
    ) u_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear_in),
      .sample_valid(sel[i]),
      .mode_in     (mode_c),
      .data        (data_in),
      .busy        (busy_out[i]),
      .done        (done[i]),
      .result      (ch_res[i])
    );
  end

  always_comb begin
    any_done = 1'b0;
    new_res  = '0;
    new_ch   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (done[i]) begin
        any_done = 1'b1;
        new_res  = ch_res[i];
        new_ch   = CH_W'(i);
      end
    end
  end

  assign transfer = result_valid_out && result_ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_out       <= '0;
      result_ch_out    <= '0;
      result_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else if (clear_in) begin
      result_out       <= '0;
      result_ch_out    <= '0;
      result_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else if (any_done) begin
      if (!result_valid_out || transfer) begin
        result_out       <= new_res;
        result_ch_out    <= new_ch;
        result_valid_out <= 1'b1;
      end else begin
        overrun_out <= 1'b1;
      end
    end else if (transfer) begin
      result_valid_out <= 1'b0;
    end
  end

endmodule
